dport_arbiter: RTL and testbench

//  Shares the single data port (port b) of the unified memory between two requesters:
//  m0 = pipeline MEM stage, m1 = UART program loader.

---
 rtl/dport_if.sv | 41 ++++
 rtl/dport_arbiter.sv | 111 +++++++++++
 tb/tb_dport_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dport_if.sv
// dport_if: bundle between the data-port arbiter, its two requesters and
// port b of the unified memory.
//   m0_*  : pipeline MEM stage  (req/we/addr/wdata in, gnt/rvalid/rdata/err out)
//   m1_*  : UART program loader (same set)
//   mem_* : memory port b (addr/wdata/we out of the arbiter, rdata back in)
//   cpu_stall : back to the hazard unit
// Modports: slave = arbiter, master = requesters, mem = memory block.
interface dport_if #(parameter int AW = 32, parameter int DW = 32);
  logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;
  logic          cpu_stall;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_addr, mem_wdata, mem_we, cpu_stall
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  cpu_stall
  );

  modport mem (
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dport_arbiter.sv
// dport_arbiter: shares memory port b between the CPU MEM stage (m0) and the
// UART loader (m1). Round-robin with boot override (boot_mode locks out m0),
// one outstanding transaction, fixed READ_LAT read latency.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   boot_mode   : 1 -> m1 is exclusive owner
//   bus         : dport_if.slave (requester handshakes, memory port, cpu_stall)
// Grants are combinational in IDLE; writes finish in the grant cycle, reads
// park in WAIT until the memory data is latched into the owner's rdata reg.
module dport_arbiter #(
  parameter int READ_LAT = 1,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input logic   clk,
  input logic   rst_n,
  input logic   boot_mode,
  dport_if.slave bus
);
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic                last_q;    // last granted requester, 1 = m1
  logic                owner_q;   // requester owning the read in flight
  logic [CW-1:0]       cnt_q;
  logic [AW-1:0]       addr_q;
  logic [1:0][DW-1:0]  rdata_q;
  logic [1:0]          rvalid_q;

  logic [1:0]          req, we, gnt, err;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  wdata;
  logic                win, grant, aligned;

  // m0 is invisible to arbitration while the loader owns the port
  assign req   = {bus.m1_req, bus.m0_req & ~boot_mode};
  assign we    = {bus.m1_we, bus.m0_we};
  assign addr  = {bus.m1_addr, bus.m0_addr};
  assign wdata = {bus.m1_wdata, bus.m0_wdata};

  // Tie goes to whoever did not win last; otherwise the lone requester
  assign win     = (req == 2'b11) ? ~last_q : req[1];
  assign grant   = (state_q == IDLE) && (req != 2'b00);
  assign aligned = (addr[win][1:0] == 2'b00);

  always_comb begin
    state_d       = state_q;
    gnt           = '0;
    err           = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    case (state_q)
      IDLE: if (grant) begin
        gnt[win]      = 1'b1;
        err[win]      = ~aligned;
        bus.mem_addr  = addr[win];
        bus.mem_wdata = wdata[win];
        bus.mem_we    = we[win] & aligned;
        if (aligned && !we[win]) state_d = WAIT;
      end
      WAIT: begin
        // address held so the memory keeps presenting the owner's word
        bus.mem_addr = addr_q;
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= '0;
      if (grant) last_q <= win;
      if (state_q == IDLE && state_d == WAIT) begin
        owner_q <= win;
        addr_q  <= addr[win];
        cnt_q   <= CW'(READ_LAT - 1);
      end
      if (state_q == WAIT) begin
        if (cnt_q == '0) begin
          rdata_q[owner_q]  <= bus.mem_rdata;
          rvalid_q[owner_q] <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_err    = err[0];
  assign bus.m1_err    = err[1];
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.cpu_stall = bus.m0_req & ~gnt[0];
endmodule

// File: tb/tb_dport_arbiter.sv
// Bench for dport_arbiter: directed scenarios followed by random traffic.
// A predictor derives the expected grant/memory-port behaviour each cycle from
// the arbitration rules (busy-until cycle, last winner, golden memory) and
// queues expected read returns; a monitor pops them when rvalid appears.
module tb_dport_arbiter;
  localparam int READ_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic boot_mode = 1'b0;
  always #5 clk = ~clk;

  dport_if #(.AW(32), .DW(32)) bus ();

  dport_arbiter #(.READ_LAT(READ_LAT), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory behind port b (256 words, upper address bits alias)
  logic [31:0] ram  [0:255];
  logic [31:0] gmem [0:255];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[9:2]];
  end

  typedef struct {int who; int due; logic [31:0] data;} exp_t;
  exp_t expq[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- predictor ----------------
  initial begin
    int          free_at, w;
    bit          last, idle, any, e0, e1, wr, al;
    logic [31:0] wait_addr, a, d, ea, ed;
    logic [1:0]  eg, ee;
    logic        ewe;
    free_at = 0; last = 1'b1; wait_addr = '0;
    forever begin
      @(negedge clk);
      idle = (cyc >= free_at);
      e0 = bus.m0_req && !boot_mode;
      e1 = bus.m1_req;
      any = idle && (e0 || e1);
      eg = '0; ee = '0; ewe = 1'b0; ea = '0; ed = '0; w = 0;
      a = '0; d = '0; wr = 1'b0; al = 1'b0;
      if (!idle) ea = wait_addr;
      if (any) begin
        w  = (e0 && e1) ? (last ? 0 : 1) : (e1 ? 1 : 0);
        a  = w ? bus.m1_addr : bus.m0_addr;
        d  = w ? bus.m1_wdata : bus.m0_wdata;
        wr = w ? bus.m1_we : bus.m0_we;
        al = (a[1:0] == 2'b00);
        eg[w] = 1'b1; ee[w] = !al; ewe = wr && al; ea = a; ed = d;
      end
      check("ctrl{g1,g0,e1,e0,we,stall}",
            {58'd0, bus.m1_gnt, bus.m0_gnt, bus.m1_err, bus.m0_err, bus.mem_we, bus.cpu_stall},
            {58'd0, eg, ee, ewe, bus.m0_req && !eg[0]});
      check("mem_addr", {32'd0, bus.mem_addr}, {32'd0, ea});
      check("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, ed});
      if (ewe) gmem[a[9:2]] = d;
      if (!rst_n) begin
        free_at = cyc + 1;
        last = 1'b1;
        while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
      end else if (any) begin
        last = (w == 1);
        if (al && !wr) begin
          free_at = cyc + READ_LAT + 1;
          wait_addr = a;
          expq.push_back('{w, cyc + READ_LAT + 1, gmem[a[9:2]]});
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit x0, x1;
    forever begin
      @(negedge clk);
      x0 = expq.size() > 0 && expq[0].due == cyc && expq[0].who == 0;
      x1 = expq.size() > 0 && expq[0].due == cyc && expq[0].who == 1;
      check("rvalid{m1,m0}", {62'd0, bus.m1_rvalid, bus.m0_rvalid}, {62'd0, x1, x0});
      if (x0 || x1) begin
        check("rdata", {32'd0, x1 ? bus.m1_rdata : bus.m0_rdata}, {32'd0, expq[0].data});
        void'(expq.pop_front());
      end else if (expq.size() > 0 && expq[0].due < cyc) begin
        void'(expq.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  task automatic wait_gnt(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = (i == 0) ? bus.m0_gnt : bus.m1_gnt;
    end
    check("gnt_wait", {63'd0, got}, 64'd1);
  endtask

  task automatic issue(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
    set_req(i, 1'b1, we, a, d);
    wait_gnt(i);
    @(posedge clk); #1;
    set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) == 0) a[31:16] = 16'hffff;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit g0, g1, act;
    for (int k = 0; k < 256; k++) begin
      ram[k]  = 32'hc0de_0000 ^ (k * 32'h0001_0203);
      gmem[k] = 32'hc0de_0000 ^ (k * 32'h0001_0203);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rdata", {bus.m1_rdata, bus.m0_rdata}, 64'd0);
    idle(1);

    // both writers held 4 cycles: m0,m1,m0,m1
    set_req(0, 1'b1, 1'b1, 32'h0000_0200, 32'h1111_aaaa);
    set_req(1, 1'b1, 1'b1, 32'h0000_0204, 32'h2222_bbbb);
    idle(4);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    idle(2);

    // m0 read 0x100, then MMIO write passthrough
    issue(0, 1'b0, 32'h0000_0100, '0);
    idle(3);
    issue(0, 1'b1, 32'hffff_ff0c, 32'h0000_005a);
    idle(2);

    // misaligned m1 write must not touch 0x100
    issue(1, 1'b1, 32'h0000_0102, 32'hdead_beef);
    issue(0, 1'b0, 32'h0000_0100, '0);
    idle(3);

    // boot mode: only m1 served, then m0 once released
    boot_mode = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h0000_0104, '0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0108, '0);
    idle(6);
    boot_mode = 1'b0;
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_gnt(0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    idle(3);

    // reset while a read is in WAIT: read dropped
    set_req(0, 1'b1, 1'b0, 32'h0000_010c, '0);
    wait_gnt(0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_mid_wait_rdata", {bus.m1_rdata, bus.m0_rdata}, 64'd0);
    idle(3);

    // random traffic
    repeat (400) begin
      @(negedge clk);
      g0 = bus.m0_gnt; g1 = bus.m1_gnt;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        act = (i == 0) ? bus.m0_req : bus.m1_req;
        if (act && (((i == 0) ? g0 : g1) || $urandom_range(0, 39) == 0)) begin
          set_req(i, 1'b0, 1'b0, '0, '0);
          act = 1'b0;
        end
        if (!act && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      if ($urandom_range(0, 29) == 0) boot_mode = ~boot_mode;
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    boot_mode = 1'b0;
    idle(6);
    check("drain_pending_reads", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
